// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter feeding the detector X input: shifts pattern[len-1:0] MSB-first,
// repeats with idle gaps. Optional macro PATTERN_GEN_LFSR_EN fills gaps with LFSR noise.
`timescale 1ns/1ps
module serial_pattern_gen #(
    parameter int   PAT_W      = 16,
    parameter int   LEN_W      = 5,
    parameter int   REP_W      = 4,
    parameter int   GAP_W      = 4,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             X,
    output logic             X_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    // Saturate the requested length to PAT_W and return the index of the first bit sent.
    function automatic logic [IDX_W-1:0] sat_top_idx(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] l;
        l = (len > PAT_W_L) ? PAT_W_L : len;
        l = l - LEN_W'(1);
        return l[IDX_W-1:0];
    endfunction

    state_t             state, state_nx;
    logic [PAT_W-1:0]   pat_r, pat_nx;
    logic [IDX_W-1:0]   top_r, top_nx;
    logic [IDX_W-1:0]   idx_r, idx_nx;
    logic [REP_W-1:0]   rep_r, rep_nx;
    logic [GAP_W-1:0]   gap_r, gap_nx;
    logic [GAP_W-1:0]   gcnt_r, gcnt_nx;
    logic               x_nx, xv_nx, busy_nx, done_nx;
    logic               gap_x;

`ifdef PATTERN_GEN_LFSR_EN
    logic [6:0] lfsr_r;
    logic       lfsr_step;

    // The LFSR advances once per gap cycle, as that cycle's bit is loaded into X.
    assign lfsr_step = (state_nx == GAP);
    assign gap_x     = lfsr_r[6];

    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr_r <= 7'h7F;
        end else if (lfsr_step) begin
            lfsr_r <= {lfsr_r[5:0], lfsr_r[6] ^ lfsr_r[5]};
        end
    end
`else
    assign gap_x = IDLE_LEVEL;
`endif

    // Next-state logic computes the values X and friends will hold next cycle, so all outputs are registered.
    always_comb begin
        state_nx = state;
        pat_nx   = pat_r;
        top_nx   = top_r;
        idx_nx   = idx_r;
        rep_nx   = rep_r;
        gap_nx   = gap_r;
        gcnt_nx  = gcnt_r;
        x_nx     = IDLE_LEVEL;
        xv_nx    = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (start && (length != '0)) begin
                    state_nx = SHIFT;
                    pat_nx   = pattern;
                    top_nx   = sat_top_idx(length);
                    rep_nx   = (reps == '0) ? '0 : reps - REP_W'(1);
                    gap_nx   = gap;
                    idx_nx   = top_nx;
                    x_nx     = pattern[top_nx];
                    xv_nx    = 1'b1;
                    busy_nx  = 1'b1;
                end
            end
            SHIFT: begin
                // rep_r holds the repetitions still owed after the one currently on the line.
                if (idx_r != '0) begin
                    idx_nx  = idx_r - IDX_W'(1);
                    x_nx    = pat_r[idx_nx];
                    xv_nx   = 1'b1;
                    busy_nx = 1'b1;
                end else if (rep_r != '0) begin
                    rep_nx  = rep_r - REP_W'(1);
                    busy_nx = 1'b1;
                    if (gap_r != '0) begin
                        state_nx = GAP;
                        gcnt_nx  = gap_r - GAP_W'(1);
                        x_nx     = gap_x;
                    end else begin
                        idx_nx = top_r;
                        x_nx   = pat_r[top_r];
                        xv_nx  = 1'b1;
                    end
                end else begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end
            end
            GAP: begin
                busy_nx = 1'b1;
                if (gcnt_r != '0) begin
                    gcnt_nx = gcnt_r - GAP_W'(1);
                    x_nx    = gap_x;
                end else begin
                    state_nx = SHIFT;
                    idx_nx   = top_r;
                    x_nx     = pat_r[top_r];
                    xv_nx    = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            pat_r   <= '0;
            top_r   <= '0;
            idx_r   <= '0;
            rep_r   <= '0;
            gap_r   <= '0;
            gcnt_r  <= '0;
            X       <= IDLE_LEVEL;
            X_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            pat_r   <= pat_nx;
            top_r   <= top_nx;
            idx_r   <= idx_nx;
            rep_r   <= rep_nx;
            gap_r   <= gap_nx;
            gcnt_r  <= gcnt_nx;
            X       <= x_nx;
            X_valid <= xv_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen; output streams are captured per cycle as bit vectors
// (bit i-1 = cycle i after the start sample) and compared against hand-derived constants.
`timescale 1ns/1ps
module tb_serial_pattern_gen;

    logic        CLK = 1'b0;
    logic        RST, start;
    logic [15:0] pattern;
    logic [4:0]  length;
    logic [3:0]  reps, gap;
    logic        X, X_valid, busy, done;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] xs, vs, bs, ds;
    logic [31:0] ex;
    logic [6:0]  lf;
    logic [3:0]  g;

    always #5 CLK = ~CLK;

    serial_pattern_gen dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .pattern (pattern),
        .length  (length),
        .reps    (reps),
        .gap     (gap),
        .X       (X),
        .X_valid (X_valid),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Pulse start, then record ncyc cycles; at cycle re_cyc start is raised again with altered inputs.
    task automatic run(input logic [15:0] pat, input logic [4:0] len, input logic [3:0] rp,
                       input logic [3:0] gp, input int ncyc, input int re_cyc);
        pattern = pat;
        length  = len;
        reps    = rp;
        gap     = gp;
        start   = 1'b1;
        tick();
        start = 1'b0;
        xs = '0; vs = '0; bs = '0; ds = '0;
        for (int i = 1; i <= ncyc; i++) begin
            xs[i-1] = X;
            vs[i-1] = X_valid;
            bs[i-1] = busy;
            ds[i-1] = done;
            if (i == re_cyc) begin
                start   = 1'b1;
                pattern = ~pat;
                length  = len + 5'd1;
                reps    = 4'd3;
            end else begin
                start   = 1'b0;
                pattern = pat;
                length  = len;
                reps    = rp;
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; pattern = '0; length = '0; reps = '0; gap = '0;
        tick();
        tick();
        chk("rst_x", 32'(X), 32'd1);
        chk("rst_xvalid", 32'(X_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        RST = 1'b0;
        tick();

        // len 4, 0010, single rep; start re-raised during DONE must be ignored
        run(16'h0002, 5'd4, 4'd1, 4'd0, 8, 5);
        chk("t1_x", xs, 32'hF4);
        chk("t1_valid", vs, 32'h0F);
        chk("t1_busy", bs, 32'h0F);
        chk("t1_done", ds, 32'h10);

        // len 3, 101, 3 reps, gap 2
        run(16'h0005, 5'd3, 4'd3, 4'd2, 15, 0);
        chk("t2_x", xs, 32'h77BD);
        chk("t2_valid", vs, 32'h1CE7);
        chk("t2_busy", bs, 32'h1FFF);
        chk("t2_done", ds, 32'h2000);

        // length 0 is ignored
        run(16'hFFFF, 5'd0, 4'd1, 4'd0, 4, 0);
        chk("len0_x", xs, 32'hF);
        chk("len0_valid", vs, 32'h0);
        chk("len0_busy", bs, 32'h0);
        chk("len0_done", ds, 32'h0);

        // length 20 clamps to 16
        run(16'h8001, 5'd20, 4'd1, 4'd0, 18, 0);
        chk("clamp_x", xs, 32'h38001);
        chk("clamp_valid", vs, 32'hFFFF);
        chk("clamp_busy", bs, 32'hFFFF);
        chk("clamp_done", ds, 32'h10000);

        // start with new inputs at cycle 2 of a len-6 run has no effect
        run(16'h002D, 5'd6, 4'd1, 4'd0, 9, 2);
        chk("busy_start_x", xs, 32'h1ED);
        chk("busy_start_valid", vs, 32'h3F);
        chk("busy_start_busy", bs, 32'h3F);
        chk("busy_start_done", ds, 32'h40);

        // reps = 15 runs all repetitions without wrapping
        run(16'h0000, 5'd1, 4'd15, 4'd0, 17, 0);
        chk("rep15_x", xs, 32'h18000);
        chk("rep15_valid", vs, 32'h7FFF);
        chk("rep15_done", ds, 32'h8000);

        // reps = 0 behaves as one repetition
        run(16'h0001, 5'd2, 4'd0, 4'd0, 4, 0);
        chk("rep0_x", xs, 32'hE);
        chk("rep0_valid", vs, 32'h3);
        chk("rep0_done", ds, 32'h4);

        // reset at cycle 3 of a len-8 run aborts without done
        pattern = 16'h00A5; length = 5'd8; reps = 4'd1; gap = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        xs = '0;
        for (int i = 1; i <= 3; i++) begin
            xs[i-1] = X;
            if (i == 3) RST = 1'b1;
            tick();
        end
        chk("rst_mid_bits", xs, 32'h5);
        chk("rst_mid_out", {28'd0, X, X_valid, busy, done}, 32'h8);
        RST = 1'b0;
        ds = '0;
        for (int i = 0; i < 8; i++) begin
            ds[i] = done | busy | X_valid;
            tick();
        end
        chk("rst_mid_quiet", ds, 32'h0);
        run(16'h0002, 5'd2, 4'd2, 4'd1, 7, 0);
        chk("after_rst_x", xs, 32'h6D);
        chk("after_rst_valid", vs, 32'h1B);
        chk("after_rst_busy", bs, 32'h1F);
        chk("after_rst_done", ds, 32'h20);

        // gap content: LFSR noise from seed 7F when enabled, otherwise idle level
        do_reset();
        lf = 7'h7F;
        for (int k = 0; k < 4; k++) begin
`ifdef PATTERN_GEN_LFSR_EN
            g[k] = lf[6];
            lf = {lf[5:0], lf[6] ^ lf[5]};
`else
            g[k] = 1'b1;
`endif
        end
        run(16'h0001, 5'd2, 4'd2, 4'd4, 10, 0);
        ex = 32'h0;
        ex[1] = 1'b1;
        for (int k = 0; k < 4; k++) ex[2+k] = g[k];
        ex[7] = 1'b1;
        ex[8] = 1'b1;
        ex[9] = 1'b1;
        chk("gap_x", xs, ex);
        chk("gap_valid", vs, 32'hC3);
        chk("gap_busy", bs, 32'hFF);
        chk("gap_done", ds, 32'h100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
Serial stimulus transmitter that drives the single-bit X input of the team's sequence-detector FSMs. It captures a pattern word, length, repeat count and inter-repeat gap, then shifts the pattern out MSB-first, one bit per CLK. Repeats are separated by idle gaps. It sits in the same design as the detector, so bench and board can replay detector test sequences autonomously.

Parameters:
PAT_W, 16, width of pattern register / maximum sequence length in bits
LEN_W, 5, width of length input; must hold PAT_W
REP_W, 4, width of repeat-count input
GAP_W, 4, width of gap-length input
IDLE_LEVEL, 1'b1, value driven on X when not transmitting pattern bits

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
start  in  1  request to begin transmission; sampled only in IDLE
pattern  in  PAT_W  sequence bits; field pattern[len-1:0] is used, bit len-1 is sent first
length  in  LEN_W  number of bits per repetition
reps  in  REP_W  number of repetitions; 0 treated as 1
gap  in  GAP_W  idle cycles inserted between repetitions (not after the last one)
X  out  1  serial bit stream to the detector
X_valid  out  1  high while X carries a pattern bit
busy  out  1  high in SHIFT and GAP states
done  out  1  one-cycle pulse after the final bit

Behaviour:
- Reset (synchronous, RST=1 at CLK edge): state=IDLE, X=IDLE_LEVEL, X_valid=0, busy=0, done=0, all counters and shadow registers cleared. Reset mid-stream aborts immediately with no done pulse.
- All outputs are registered.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 and length!=0: capture pattern, length, reps and gap into shadow registers; go to SHIFT.
  - length>PAT_W: clamp to PAT_W.
  - start=1 with length=0: ignored, stay IDLE.
- SHIFT:
  - First pattern bit appears on X the cycle after start is sampled (latency 1).
  - Each bit is held exactly one cycle, with X_valid=1.
  - Bit index counts len-1 down to 0.
  - After bit 0 with repetitions remaining: go to GAP if gap!=0, else restart bit index at len-1 (back-to-back, no bubble).
  - After bit 0 of the last repetition: go to DONE.
- GAP: X=IDLE_LEVEL, X_valid=0, busy=1 for exactly gap cycles, then SHIFT with bit index reloaded.
- DONE: single cycle with done=1, busy=0, X=IDLE_LEVEL; then IDLE. start asserted in DONE is ignored.
- start while busy is ignored. Input changes after capture have no effect.
- Repetition counter is REP_W wide; reps=2^REP_W-1 must run fully with no wrap.
- Total cycles from start sample to done: reps*len + (reps-1)*gap + 1.

Optional Feature:
Macro PATTERN_GEN_LFSR_EN.
- Defined: during GAP, X is driven from a 7-bit Fibonacci LFSR (x^7+x^6+1). Reset seed is 7'h7F. The LFSR advances only on GAP cycles, and its output bit goes to X. X_valid stays 0. This exercises detector robustness to noise between sequences.
- Undefined: GAP drives X=IDLE_LEVEL. No LFSR logic is synthesised.

Test Plan:
1. length=4, pattern=16'h0002, reps=1, gap=0, start pulse at cycle 0 -> X=0,0,1,0 at cycles 1-4 with X_valid=1; done=1 at cycle 5; busy=1 at cycles 1-4 only.
2. length=3, pattern=16'h0005, reps=3, gap=2 -> X_valid pattern 111 00 111 00 111; X bits 101 each repetition; done at cycle 14 (3*3+2*2+1).
3. length=0 with start -> no state change, busy stays 0. length=20, pattern=16'h8001 -> 16 bits sent (1, fourteen 0s, 1), done at cycle 17.
4. start re-asserted at cycle 2 of a length-6 run with a new pattern -> original 6 bits unchanged; no second run; single done pulse.
5. RST=1 at cycle 3 of a length-8 run -> next cycle X=IDLE_LEVEL, X_valid=0, busy=0; no done; a fresh start afterwards runs normally.
6. PATTERN_GEN_LFSR_EN defined, reps=2, gap=4 -> the 4 gap cycles on X equal the first 4 LFSR outputs from seed 7'h7F; X_valid=0 throughout the gap.
